// File: rtl/mult_addsub_pipe_pkg.sv
// Shared fixed-point constants and saturation bounds for the mult/add-sub datapath.
package mult_addsub_pipe_pkg;

    localparam int unsigned FXP_DATA_WIDTH = 20;
    localparam int unsigned FXP_FRAC       = 16;

    // 1.0 in the default Q4.16 format
    localparam logic signed [FXP_DATA_WIDTH-1:0] FXP_ONE =
        FXP_DATA_WIDTH'(64'sd1 <<< FXP_FRAC);

    function automatic logic signed [63:0] sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational sum -> round -> shift -> overflow detect of two full-precision products.
// Build option MULT_ADDSUB_SAT_EN clamps overflowing results instead of wrapping them.
module fxp_round_sat
    import mult_addsub_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FXP_DATA_WIDTH,
    parameter int unsigned FRAC       = FXP_FRAC,
    parameter int unsigned ROUND      = 1
) (
    input  logic signed [2*DATA_WIDTH-1:0] pa,
    input  logic signed [2*DATA_WIDTH-1:0] pb,
    input  logic                           sub,
    output logic signed [DATA_WIDTH-1:0]   res,
    output logic                           ovf
);

    localparam int unsigned SW  = 2 * DATA_WIDTH + 1;
    localparam int unsigned RSH = (FRAC > 0) ? FRAC - 1 : 0;
    localparam logic signed [SW-1:0] RND_BIAS =
        (ROUND != 0 && FRAC > 0) ? (SW'(1) << RSH) : '0;

    logic signed [SW-1:0] pa_x;
    logic signed [SW-1:0] pb_x;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] biased;
    logic signed [SW-1:0] r;

    assign pa_x   = {pa[2*DATA_WIDTH-1], pa};
    assign pb_x   = {pb[2*DATA_WIDTH-1], pb};
    assign sum    = sub ? (pa_x - pb_x) : (pa_x + pb_x);
    assign biased = sum + RND_BIAS;
    assign r      = biased >>> FRAC;

    // In range iff every bit from the result sign bit upward agrees.
    assign ovf = !((&r[SW-1:DATA_WIDTH-1]) || !(|r[SW-1:DATA_WIDTH-1]));

`ifdef MULT_ADDSUB_SAT_EN
    localparam logic signed [DATA_WIDTH-1:0] SMAX = DATA_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic signed [DATA_WIDTH-1:0] SMIN = DATA_WIDTH'(sat_min(DATA_WIDTH));

    always_comb begin
        res = r[DATA_WIDTH-1:0];
        if (ovf) begin
            res = r[SW-1] ? SMIN : SMAX;
        end
    end
`else
    assign res = r[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/mult_addsub_pipe.sv
// Three-stage a1*a2 +/- b1*b2 fixed-point unit with valid/ready on both sides.
// Saturating output when built with MULT_ADDSUB_SAT_EN, two's-complement wrap otherwise.
module mult_addsub_pipe
    import mult_addsub_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FXP_DATA_WIDTH,
    parameter int unsigned FRAC       = FXP_FRAC,
    parameter int unsigned ROUND      = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sub,
    input  logic signed [DATA_WIDTH-1:0] a1,
    input  logic signed [DATA_WIDTH-1:0] a2,
    input  logic signed [DATA_WIDTH-1:0] b1,
    input  logic signed [DATA_WIDTH-1:0] b2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out,
    output logic                         out_ovf
);

    localparam int unsigned PW = 2 * DATA_WIDTH;

    logic                         v1_q, v2_q, v3_q;
    logic                         en1, en2, en3;
    logic                         sub1_q, sub2_q;
    logic signed [DATA_WIDTH-1:0] a1_q, a2_q, b1_q, b2_q;
    logic signed [PW-1:0]         pa_d, pb_d, pa_q, pb_q;
    logic signed [DATA_WIDTH-1:0] res_d, out_q;
    logic                         ovf_d, ovf_q;

    // A stage loads when empty or when its contents move on this cycle; bubbles collapse.
    always_comb begin
        en3 = !v3_q || out_ready;
        en2 = !v2_q || en3;
        en1 = !v1_q || en2;
    end

    assign in_ready  = en1;
    assign out_valid = v3_q;
    assign out       = out_q;
    assign out_ovf   = ovf_q;

    always_comb begin
        pa_d = PW'(a1_q) * PW'(a2_q);
        pb_d = PW'(b1_q) * PW'(b2_q);
    end

    fxp_round_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC       (FRAC),
        .ROUND      (ROUND)
    ) u_round_sat (
        .pa  (pa_q),
        .pb  (pb_q),
        .sub (sub2_q),
        .res (res_d),
        .ovf (ovf_d)
    );

    // Control and the visible output registers are reset; out reads 0 whenever it is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            out_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (en1) v1_q <= in_valid;
            if (en2) v2_q <= v1_q;
            if (en3) begin
                v3_q  <= v2_q;
                out_q <= v2_q ? res_d : '0;
                ovf_q <= v2_q & ovf_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en1 && in_valid) begin
            a1_q   <= a1;
            a2_q   <= a2;
            b1_q   <= b1;
            b2_q   <= b2;
            sub1_q <= in_sub;
        end
        if (en2 && v1_q) begin
            pa_q   <= pa_d;
            pb_q   <= pb_d;
            sub2_q <= sub1_q;
        end
    end

endmodule
